// File: rtl/hdsiso_pkg.sv
// Shared definitions for the PRBS8 generator/checker pair.
// Holds the LFSR width, the feedback tap mask for x^8+x^6+x^5+x^4+1
// (taps S[7], S[5], S[4], S[3]) and the checker state encoding.
package hdsiso_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b1011_1000;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

  // Next PRBS bit predicted from the last LFSR_W bits (S[0] newest).
  function automatic logic prbs_fb(input logic [LFSR_W-1:0] s);
    return ^(s & TAP_MASK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   - clock, rising edge
//   clr_i   - synchronous clear, wins over inc_i
//   inc_i   - increment enable; holds at all-ones once reached
//   count_o - current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lfsr8_check.sv
// PRBS8 receive checker.
// Hunts for the PRBS8 sequence by filling an 8-bit shift register with
// received bits, then free-runs the LFSR on its own predictions and compares
// every valid received bit against the prediction. Too many mismatches in one
// window of checked bits drops lock and restarts the hunt.
// Ports:
//   CLK        - clock, rising edge
//   RESET      - synchronous active-high reset
//   CHK_EN     - bit-valid qualifier; everything freezes when low
//   D_IN       - received serial stream
//   LOCKED     - checker is synchronised (state CHECK)
//   ERR        - one-cycle pulse per mismatched bit while locked
//   ERR_COUNT  - total mismatches, saturating at 255
//   LOSS_COUNT - lock losses, saturating at 15
module lfsr8_check
  import hdsiso_pkg::*;
#(
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned WINDOW      = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CHK_EN,
  input  logic       D_IN,
  output logic       LOCKED,
  output logic       ERR,
  output logic [7:0] ERR_COUNT,
  output logic [3:0] LOSS_COUNT
);

  localparam int unsigned WCNT_W = $clog2(WINDOW);
  localparam int unsigned EWIN_W = WCNT_W + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
  localparam logic [EWIN_W-1:0] EWIN_LOSS = EWIN_W'(LOSS_THRESH);
  localparam logic [3:0]        FILL_FULL = 4'(LFSR_W);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] s_q, s_d;
  logic [3:0]        fill_q, fill_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [EWIN_W-1:0] ewin_q, ewin_d;
  logic              err_q, err_d;

  logic              exp_bit;
  logic              mism;
  logic              loss;
  logic              hunt_done;
  logic [LFSR_W-1:0] s_hunt;
  logic [3:0]        fill_inc;
  logic [EWIN_W-1:0] ewin_inc;

  // Qualified events for this edge, shared by next-state and datapath logic.
  always_comb begin
    exp_bit   = prbs_fb(s_q);
    s_hunt    = {s_q[LFSR_W-2:0], D_IN};
    fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + 4'd1;
    mism      = 1'b0;
    loss      = 1'b0;
    hunt_done = 1'b0;
    ewin_inc  = ewin_q;
    if (CHK_EN) begin
      if (state_q == HUNT) begin
        hunt_done = (fill_inc == FILL_FULL) && (s_hunt != '0);
      end else begin
        mism     = D_IN ^ exp_bit;
        ewin_inc = ewin_q + EWIN_W'(mism);
        loss     = mism && (ewin_inc == EWIN_LOSS);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      wcnt_q  <= '0;
      ewin_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      wcnt_q  <= wcnt_d;
      ewin_q  <= ewin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (hunt_done) state_d = CHECK;
      CHECK:   if (loss)      state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // In CHECK the register is fed with the prediction, not the received bit,
  // so a single channel error is seen exactly once. Loss beats window wrap.
  always_comb begin
    s_d    = s_q;
    fill_d = fill_q;
    wcnt_d = wcnt_q;
    ewin_d = ewin_q;
    err_d  = mism;
    if (CHK_EN) begin
      if (state_q == HUNT) begin
        s_d    = s_hunt;
        fill_d = fill_inc;
      end else if (loss) begin
        s_d    = '0;
        fill_d = '0;
        wcnt_d = '0;
        ewin_d = '0;
      end else begin
        s_d = {s_q[LFSR_W-2:0], exp_bit};
        if (wcnt_q == WCNT_LAST) begin
          wcnt_d = '0;
          ewin_d = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          ewin_d = ewin_inc;
        end
      end
    end
  end

  always_comb begin
    LOCKED = (state_q == CHECK);
    ERR    = err_q;
  end

  sat_counter #(.WIDTH(8)) u_err_count (
    .clk_i   (CLK),
    .clr_i   (RESET),
    .inc_i   (mism),
    .count_o (ERR_COUNT)
  );

  sat_counter #(.WIDTH(4)) u_loss_count (
    .clk_i   (CLK),
    .clr_i   (RESET),
    .inc_i   (loss),
    .count_o (LOSS_COUNT)
  );

endmodule

// File: tb/tb_lfsr8_check.sv
// Directed bench for lfsr8_check: a reference PRBS8 source (seed 8'h01)
// drives the checker through lock, single errors, loss of lock, all-zero
// input, ERR_COUNT/LOSS_COUNT saturation, CHK_EN freeze and reset priority.
module tb_lfsr8_check;

  logic       CLK;
  logic       RESET;
  logic       CHK_EN;
  logic       D_IN;
  logic       LOCKED;
  logic       ERR;
  logic [7:0] ERR_COUNT;
  logic [3:0] LOSS_COUNT;

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;
  logic [7:0]  g;
  logic        b;

  lfsr8_check #(.LOSS_THRESH(4), .WINDOW(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CHK_EN     (CHK_EN),
    .D_IN       (D_IN),
    .LOCKED     (LOCKED),
    .ERR        (ERR),
    .ERR_COUNT  (ERR_COUNT),
    .LOSS_COUNT (LOSS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference source: b[n] = b[n-8]^b[n-6]^b[n-5]^b[n-4].
  task automatic next_bit(output logic nb);
    nb = g[7] ^ g[5] ^ g[4] ^ g[3];
    g  = {g[6:0], nb};
  endtask

  task automatic drive(input logic en, input logic d);
    CHK_EN = en;
    D_IN   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    RESET = 1'b0;
    g = 8'h01;
  endtask

  initial begin
    RESET  = 1'b1;
    CHK_EN = 1'b0;
    D_IN   = 1'b0;
    g      = 8'h01;

    // Reset state
    do_reset();
    chk("rst_locked", LOCKED, 0);
    chk("rst_err", ERR, 0);
    chk("rst_errcnt", ERR_COUNT, 0);
    chk("rst_losscnt", LOSS_COUNT, 0);

    // Clean stream: lock the edge after bit 8, never an error
    for (int k = 1; k <= 300; k++) begin
      next_bit(b);
      drive(1'b1, b);
      chk($sformatf("clean_locked@%0d", k), LOCKED, (k >= 8));
      chk($sformatf("clean_err@%0d", k), ERR, 0);
    end
    chk("clean_errcnt", ERR_COUNT, 0);

    // Single inverted bit 100
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      next_bit(b);
      drive(1'b1, (k == 100) ? ~b : b);
      chk($sformatf("single_locked@%0d", k), LOCKED, (k >= 8));
      chk($sformatf("single_err@%0d", k), ERR, (k == 100));
    end
    chk("single_errcnt", ERR_COUNT, 1);
    chk("single_losscnt", LOSS_COUNT, 0);

    // Bits 100..103 inverted: loss at 103, relock after bits 104..111
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      next_bit(b);
      drive(1'b1, (k >= 100 && k <= 103) ? ~b : b);
      chk($sformatf("burst_locked@%0d", k), LOCKED, (k >= 8) && !(k >= 103 && k <= 110));
      chk($sformatf("burst_err@%0d", k), ERR, (k >= 100 && k <= 103));
    end
    chk("burst_errcnt", ERR_COUNT, 4);
    chk("burst_losscnt", LOSS_COUNT, 1);

    // All-zero input never locks
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      drive(1'b1, 1'b0);
      chk($sformatf("zero_locked@%0d", k), LOCKED, 0);
    end
    chk("zero_errcnt", ERR_COUNT, 0);

    // One inverted bit every 16: stays locked, ERR_COUNT saturates
    do_reset();
    for (int k = 1; k <= 4500; k++) begin
      next_bit(b);
      drive(1'b1, (k % 16 == 0) ? ~b : b);
      chk($sformatf("sat_locked@%0d", k), LOCKED, (k >= 8));
      chk($sformatf("sat_err@%0d", k), ERR, (k % 16 == 0));
      if (k == 4064) chk("sat_errcnt_254", ERR_COUNT, 254);
      if (k == 4080) chk("sat_errcnt_255", ERR_COUNT, 255);
    end
    chk("sat_errcnt_end", ERR_COUNT, 255);
    chk("sat_losscnt", LOSS_COUNT, 0);

    // 16 lock/loss cycles: LOSS_COUNT saturates at 15
    do_reset();
    for (int r = 1; r <= 16; r++) begin
      for (int j = 0; j < 8; j++) begin
        next_bit(b);
        drive(1'b1, b);
      end
      chk($sformatf("lsat_locked@%0d", r), LOCKED, 1);
      for (int j = 0; j < 4; j++) begin
        next_bit(b);
        drive(1'b1, ~b);
        chk($sformatf("lsat_err@%0d.%0d", r, j), ERR, 1);
      end
      chk($sformatf("lsat_unlocked@%0d", r), LOCKED, 0);
      chk($sformatf("lsat_losscnt@%0d", r), LOSS_COUNT, (r < 15) ? r : 15);
    end
    chk("lsat_errcnt", ERR_COUNT, 64);

    // Freeze with CHK_EN=0, resume, then reset with a simultaneous error
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      next_bit(b);
      drive(1'b1, (k == 15) ? ~b : b);
    end
    chk("frz_pre_locked", LOCKED, 1);
    chk("frz_pre_errcnt", ERR_COUNT, 1);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, k[0]);
      chk($sformatf("frz_locked@%0d", k), LOCKED, 1);
      chk($sformatf("frz_err@%0d", k), ERR, 0);
      chk($sformatf("frz_errcnt@%0d", k), ERR_COUNT, 1);
      chk($sformatf("frz_losscnt@%0d", k), LOSS_COUNT, 0);
    end
    for (int k = 0; k < 10; k++) begin
      next_bit(b);
      drive(1'b1, b);
      chk($sformatf("resume_err@%0d", k), ERR, 0);
      chk($sformatf("resume_locked@%0d", k), LOCKED, 1);
    end
    next_bit(b);
    RESET = 1'b1;
    drive(1'b1, ~b);
    RESET = 1'b0;
    chk("rst2_locked", LOCKED, 0);
    chk("rst2_err", ERR, 0);
    chk("rst2_errcnt", ERR_COUNT, 0);
    chk("rst2_losscnt", LOSS_COUNT, 0);
    g = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      next_bit(b);
      drive(1'b1, b);
      chk($sformatf("rst2_relock@%0d", k), LOCKED, (k == 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
